// File: rtl/alt_vipcti131_mode_lock_encoder.sv
// ---------------------------------------------------------------------------
// alt_vipcti131_mode_lock_encoder
//
// Registered one-hot to binary mode encoder with lock/unlock hysteresis for
// the clocked video input. Each measurement's one-hot mode-match vector is
// priority-encoded to index+1 (0 = no match). A mode is only reported after
// LOCK_COUNT consecutive identical non-zero candidates. It is only dropped
// after UNLOCK_COUNT consecutive mismatching candidates, so a single glitched
// measurement never changes the reported mode.
//
// Ports
//   clk            single clock
//   rst            asynchronous, active-high reset
//   sample_valid   one_hot holds a new measurement this cycle
//   one_hot        mode-match vector, NO_OF_MODES bits
//   clear          synchronous clear of lock state and error flag
//   mode_binary    locked mode as index+1; 0 while not locked
//   mode_valid     1 while a mode is being reported (LOCKED or LOSING)
//   mode_change    one-cycle pulse whenever mode_binary changes value
//   multi_hot_err  sticky flag; set by any sampled vector with >1 bit set
// ---------------------------------------------------------------------------
module alt_vipcti131_mode_lock_encoder #(
    parameter int NO_OF_MODES      = 3,
    parameter int LOG2_NO_OF_MODES = 2,
    parameter int LOCK_COUNT       = 3,
    parameter int UNLOCK_COUNT     = 2,
    parameter bit PRIORITY_LOW     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [NO_OF_MODES-1:0]      one_hot,
    input  logic                        clear,
    output logic [LOG2_NO_OF_MODES-1:0] mode_binary,
    output logic                        mode_valid,
    output logic                        mode_change,
    output logic                        multi_hot_err
);

    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        LOSING   = 2'd3
    } state_t;

    // Priority encode to index+1; 0 when no bit is set. With PRIORITY_LOW
    // the scan runs high-to-low so the lowest set bit is assigned last.
    function automatic logic [LOG2_NO_OF_MODES-1:0] encode_mode(
        input logic [NO_OF_MODES-1:0] vec
    );
        logic [LOG2_NO_OF_MODES-1:0] code;
        code = '0;
        if (PRIORITY_LOW) begin
            for (int i = NO_OF_MODES - 1; i >= 0; i--) begin
                if (vec[i]) code = LOG2_NO_OF_MODES'(i + 1);
            end
        end else begin
            for (int i = 0; i < NO_OF_MODES; i++) begin
                if (vec[i]) code = LOG2_NO_OF_MODES'(i + 1);
            end
        end
        return code;
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic is_multi_hot(input logic [NO_OF_MODES-1:0] vec);
        return (vec & (vec - NO_OF_MODES'(1))) != '0;
    endfunction

    // ---- stage 1: encode the sampled vector ----
    logic [LOG2_NO_OF_MODES-1:0] cand_p1;
    logic                        vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_p1       <= '0;
            vld_p1        <= 1'b0;
            multi_hot_err <= 1'b0;
        end else if (clear) begin
            // clear wins over a coincident sample_valid
            cand_p1       <= '0;
            vld_p1        <= 1'b0;
            multi_hot_err <= 1'b0;
        end else if (sample_valid) begin
            cand_p1 <= encode_mode(one_hot);
            vld_p1  <= 1'b1;
            if (is_multi_hot(one_hot)) multi_hot_err <= 1'b1;
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    // ---- stage 2: lock/unlock hysteresis FSM ----
    state_t                      state_p2, state_nxt;
    logic [CNT_W-1:0]            cnt_p2, cnt_nxt;
    logic [MISS_W-1:0]           miss_p2, miss_nxt;
    logic [LOG2_NO_OF_MODES-1:0] held_p2, held_nxt;
    logic [LOG2_NO_OF_MODES-1:0] mode_nxt;
    logic                        mode_valid_nxt;
    logic                        mode_change_nxt;
    logic                        start_qual;
    logic                        drop_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p2    <= UNLOCKED;
            cnt_p2      <= '0;
            miss_p2     <= '0;
            held_p2     <= '0;
            mode_binary <= '0;
            mode_valid  <= 1'b0;
            mode_change <= 1'b0;
        end else begin
            state_p2    <= state_nxt;
            cnt_p2      <= cnt_nxt;
            miss_p2     <= miss_nxt;
            held_p2     <= held_nxt;
            mode_binary <= mode_nxt;
            mode_valid  <= mode_valid_nxt;
            mode_change <= mode_change_nxt;
        end
    end

    always_comb begin
        state_nxt       = state_p2;
        cnt_nxt         = cnt_p2;
        miss_nxt        = miss_p2;
        held_nxt        = held_p2;
        mode_nxt        = mode_binary;
        mode_valid_nxt  = mode_valid;
        mode_change_nxt = 1'b0;
        start_qual      = 1'b0;
        drop_lock       = 1'b0;

        if (clear) begin
            state_nxt       = UNLOCKED;
            cnt_nxt         = '0;
            miss_nxt        = '0;
            held_nxt        = '0;
            mode_nxt        = '0;
            mode_valid_nxt  = 1'b0;
            mode_change_nxt = (mode_binary != '0);
        end else if (vld_p1) begin
            unique case (state_p2)
                UNLOCKED: begin
                    if (cand_p1 != '0) start_qual = 1'b1;
                end
                LOCKING: begin
                    if (cand_p1 == held_p2) begin
                        if (int'(cnt_p2) + 1 >= LOCK_COUNT) begin
                            // counter saturates at the threshold
                            cnt_nxt         = CNT_W'(LOCK_COUNT);
                            miss_nxt        = '0;
                            mode_nxt        = held_p2;
                            mode_valid_nxt  = 1'b1;
                            mode_change_nxt = 1'b1;
                            state_nxt       = LOCKED;
                        end else begin
                            cnt_nxt = cnt_p2 + CNT_W'(1);
                        end
                    end else if (cand_p1 != '0) begin
                        held_nxt = cand_p1;
                        cnt_nxt  = CNT_W'(1);
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (cand_p1 == mode_binary) begin
                        miss_nxt = '0;
                    end else if (UNLOCK_COUNT == 1) begin
                        drop_lock = 1'b1;
                    end else begin
                        miss_nxt  = MISS_W'(1);
                        state_nxt = LOSING;
                    end
                end
                LOSING: begin
                    if (cand_p1 == mode_binary) begin
                        miss_nxt  = '0;
                        state_nxt = LOCKED;
                    end else if (int'(miss_p2) + 1 >= UNLOCK_COUNT) begin
                        drop_lock = 1'b1;
                    end else begin
                        miss_nxt = miss_p2 + MISS_W'(1);
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase

            // Dropping lock reports 0 but may immediately begin qualifying
            // the mismatching candidate that caused the drop.
            if (drop_lock) begin
                mode_nxt        = '0;
                mode_valid_nxt  = 1'b0;
                mode_change_nxt = 1'b1;
                miss_nxt        = '0;
                cnt_nxt         = '0;
                state_nxt       = UNLOCKED;
                if (cand_p1 != '0) start_qual = 1'b1;
            end

            if (start_qual) begin
                held_nxt  = cand_p1;
                cnt_nxt   = CNT_W'(1);
                state_nxt = LOCKING;
                if (LOCK_COUNT == 1) begin
                    miss_nxt        = '0;
                    mode_nxt        = cand_p1;
                    mode_valid_nxt  = 1'b1;
                    mode_change_nxt = 1'b1;
                    state_nxt       = LOCKED;
                end
            end
        end
    end

endmodule

// File: tb/tb_alt_vipcti131_mode_lock_encoder.sv
module tb_alt_vipcti131_mode_lock_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [2:0] one_hot;
    logic       clear;
    logic [1:0] mode_binary;
    logic       mode_valid;
    logic       mode_change;
    logic       multi_hot_err;

    int tests = 0;
    int fails = 0;

    alt_vipcti131_mode_lock_encoder #(
        .NO_OF_MODES      (3),
        .LOG2_NO_OF_MODES (2),
        .LOCK_COUNT       (3),
        .UNLOCK_COUNT     (2),
        .PRIORITY_LOW     (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .one_hot       (one_hot),
        .clear         (clear),
        .mode_binary   (mode_binary),
        .mode_valid    (mode_valid),
        .mode_change   (mode_change),
        .multi_hot_err (multi_hot_err)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {mode_binary, mode_valid, mode_change, multi_hot_err}
    logic [4:0] obs;
    assign obs = {mode_binary, mode_valid, mode_change, multi_hot_err};

    // Drive inputs from one falling edge to the next; on return the outputs
    // reflect the rising edge that consumed these inputs.
    task automatic cyc(input logic sv, input logic [2:0] oh, input logic clr);
        sample_valid = sv;
        one_hot      = oh;
        clear        = clr;
        @(negedge clk);
        sample_valid = 1'b0;
        one_hot      = 3'b000;
        clear        = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        one_hot      = 3'b000;
        clear        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obs !== 5'b00_0_0_0) begin
            fails++; $display("FAIL reset_state: got %b required %b", obs, 5'b00000);
        end
    endtask

    task automatic test_lock();
        cyc(1'b1, 3'b010, 1'b0);
        cyc(1'b1, 3'b010, 1'b0);
        cyc(1'b1, 3'b010, 1'b0);
        tests++;
        if (obs !== 5'b00_0_0_0) begin
            fails++; $display("FAIL lock_latency: got %b required %b", obs, 5'b00000);
        end
        cyc(1'b0, 3'b000, 1'b0);
        tests++;
        if (obs !== 5'b10_1_1_0) begin
            fails++; $display("FAIL lock_on_2: got %b required %b", obs, 5'b10110);
        end
        cyc(1'b0, 3'b000, 1'b0);
        tests++;
        if (obs !== 5'b10_1_0_0) begin
            fails++; $display("FAIL lock_pulse_once: got %b required %b", obs, 5'b10100);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] vec [3];
        vec = '{3'b100, 3'b010, 3'b000};
        for (int i = 0; i < 3; i++) begin
            cyc(vec[i] != 3'b000, vec[i], 1'b0);
            tests++;
            if (obs !== 5'b10_1_0_0) begin
                fails++; $display("FAIL glitch_step%0d: got %b required %b", i, obs, 5'b10100);
            end
        end
    endtask

    task automatic test_unlock_relock();
        logic [2:0] vec [7];
        logic [4:0] exp [7];
        vec = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
        exp = '{5'b10100, 5'b10100, 5'b00010, 5'b00000, 5'b00000, 5'b11110, 5'b11100};
        for (int i = 0; i < 7; i++) begin
            cyc(vec[i] != 3'b000, vec[i], 1'b0);
            tests++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL unlock_relock_step%0d: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_no_lock_multi_hot();
        logic [2:0] vec [5];
        logic [4:0] exp [5];
        do_reset();
        vec = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 5; i++) begin
            cyc(i < 3, vec[i], 1'b0);
            tests++;
            if (obs !== 5'b00000) begin
                fails++; $display("FAIL never_lock_step%0d: got %b required %b", i, obs, 5'b00000);
            end
        end
        vec = '{3'b110, 3'b110, 3'b110, 3'b000, 3'b000};
        exp = '{5'b00001, 5'b00001, 5'b00001, 5'b10111, 5'b10101};
        for (int i = 0; i < 5; i++) begin
            cyc(i < 3, vec[i], 1'b0);
            tests++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL multi_hot_step%0d: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic [4:0] exp [6];
        logic       sv  [6];
        // Move lock from 2 to 3; the error flag must persist throughout.
        exp = '{5'b10101, 5'b10101, 5'b00011, 5'b00001, 5'b11111, 5'b11101};
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, 3'b100, 1'b0);
            tests++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL relock_3_step%0d: got %b required %b", i, obs, exp[i]);
            end
        end
        cyc(1'b1, 3'b001, 1'b1);
        tests++;
        if (obs !== 5'b00_0_1_0) begin
            fails++; $display("FAIL clear_outputs: got %b required %b", obs, 5'b00010);
        end
        // If the sample alongside clear were kept, these two would lock mode 1.
        sv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01110};
        for (int i = 0; i < 6; i++) begin
            cyc(sv[i], 3'b001, 1'b0);
            tests++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL clear_discard_step%0d: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 3'b100, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
        tests++;
        if (obs !== 5'b01_1_0_0) begin
            fails++; $display("FAIL losing_holds_mode: got %b required %b", obs, 5'b01100);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== 5'b00000) begin
            fails++; $display("FAIL async_reset: got %b required %b", obs, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(i < 2, 3'b100, 1'b0);
            tests++;
            if (obs !== 5'b00000) begin
                fails++; $display("FAIL post_reset_step%0d: got %b required %b", i, obs, 5'b00000);
            end
        end
        cyc(1'b1, 3'b100, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
        tests++;
        if (obs !== 5'b11_1_1_0) begin
            fails++; $display("FAIL post_reset_relock: got %b required %b", obs, 5'b11110);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_unlock_relock();
        test_no_lock_multi_hot();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
